// File: rtl/main_control_pkg.sv
// main_control_pkg
//   Shared encodings for the KGP-miniRISC main control unit: opcode values,
//   ALU operation classes, register-write and branch classes, and the packed
//   control word handed from the decoder to the output register stage.
package main_control_pkg;

  // Opcode values recognised by the decoder; everything else is illegal.
  localparam logic [5:0] OP_RARITH = 6'd0;
  localparam logic [5:0] OP_RSHIFT = 6'd1;
  localparam logic [5:0] OP_ADDI   = 6'd2;
  localparam logic [5:0] OP_COMPI  = 6'd3;
  localparam logic [5:0] OP_LW     = 6'd4;
  localparam logic [5:0] OP_SW     = 6'd5;
  localparam logic [5:0] OP_BR     = 6'd6;
  localparam logic [5:0] OP_B      = 6'd7;
  localparam logic [5:0] OP_BL     = 6'd8;
  localparam logic [5:0] OP_BCOND  = 6'd9;

  // ALU operation classes forwarded to the ALU control unit (110/111 reserved).
  localparam logic [2:0] ALU_NONE   = 3'b000;
  localparam logic [2:0] ALU_RARITH = 3'b001;
  localparam logic [2:0] ALU_RSHIFT = 3'b010;
  localparam logic [2:0] ALU_ADD    = 3'b011;
  localparam logic [2:0] ALU_COMPI  = 3'b100;
  localparam logic [2:0] ALU_PASS   = 3'b101;

  // Register-write classes.
  localparam logic [1:0] RW_NONE = 2'b00;
  localparam logic [1:0] RW_RD   = 2'b01;
  localparam logic [1:0] RW_LINK = 2'b10;

  // Branch classes.
  localparam logic [1:0] BR_NONE   = 2'b00;
  localparam logic [1:0] BR_UNCOND = 2'b01;
  localparam logic [1:0] BR_COND   = 2'b10;
  localparam logic [1:0] BR_REG    = 2'b11;

  // Full datapath control word; the all-zero value is the NOP word.
  typedef struct packed {
    logic [1:0] reg_write;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] branch;
    logic       mem_to_reg;
    logic [2:0] alu_op;
    logic       alu_src;
    logic       illegal;
  } ctrl_word_t;

  localparam ctrl_word_t CTRL_NOP = ctrl_word_t'(12'h000);

endpackage

// File: rtl/main_control_decode.sv
// main_control_decode
//   Purely combinational opcode-to-control-word table.
//   Ports:
//     opcode - 6-bit instruction opcode field
//     ctrl   - decoded control word (illegal set for unlisted or X/Z opcodes)
module main_control_decode
  import main_control_pkg::*;
(
  input  logic [5:0] opcode,
  output ctrl_word_t ctrl
);

  // Opcode decode table; an unknown opcode falls to the default arm.
  always_comb begin
    ctrl = CTRL_NOP;
    case (opcode)
      OP_RARITH: begin
        ctrl.reg_write = RW_RD;
        ctrl.alu_op    = ALU_RARITH;
        ctrl.alu_src   = 1'b0;
      end
      OP_RSHIFT: begin
        ctrl.reg_write = RW_RD;
        ctrl.alu_op    = ALU_RSHIFT;
      end
      OP_ADDI: begin
        ctrl.reg_write = RW_RD;
        ctrl.alu_op    = ALU_ADD;
        ctrl.alu_src   = 1'b1;
      end
      OP_COMPI: begin
        ctrl.reg_write = RW_RD;
        ctrl.alu_op    = ALU_COMPI;
        ctrl.alu_src   = 1'b1;
      end
      OP_LW: begin
        ctrl.reg_write  = RW_RD;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.alu_op     = ALU_ADD;
        ctrl.alu_src    = 1'b1;
      end
      OP_SW: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_op    = ALU_ADD;
        ctrl.alu_src   = 1'b1;
      end
      OP_BR: begin
        ctrl.branch = BR_REG;
      end
      OP_B: begin
        ctrl.branch = BR_UNCOND;
      end
      OP_BL: begin
        ctrl.branch    = BR_UNCOND;
        ctrl.reg_write = RW_LINK;
      end
      OP_BCOND: begin
        ctrl.branch = BR_COND;
        ctrl.alu_op = ALU_PASS;
      end
      default: begin
        ctrl         = CTRL_NOP;
        ctrl.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/main_control.sv
// main_control
//   Main control unit of the KGP-miniRISC datapath. Decodes the opcode and
//   registers the control word, giving exactly one cycle of latency.
//   Ports:
//     clk        - rising-edge clock
//     rst        - asynchronous active-high reset, forces the NOP word
//     opcode     - instruction opcode field
//     reg_write  - 00 none, 01 rd, 10 link register r31
//     mem_read   - data-memory read enable
//     mem_write  - data-memory write enable
//     branch     - 00 none, 01 PC-relative, 10 conditional, 11 register
//     mem_to_reg - write-back source select (1 = memory)
//     alu_op     - ALU operation class
//     alu_src    - ALU operand B select (1 = immediate)
//     illegal    - opcode not in the decode table
module main_control
  import main_control_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  output logic [1:0] reg_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic [1:0] branch,
  output logic       mem_to_reg,
  output logic [2:0] alu_op,
  output logic       alu_src,
  output logic       illegal
);

  ctrl_word_t decode_s;
  ctrl_word_t ctrl_r;

  main_control_decode u_decode (
    .opcode (opcode),
    .ctrl   (decode_s)
  );

  // Output register stage: loads every cycle, clears asynchronously to NOP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_r <= CTRL_NOP;
    end else begin
      ctrl_r <= decode_s;
    end
  end

  assign reg_write  = ctrl_r.reg_write;
  assign mem_read   = ctrl_r.mem_read;
  assign mem_write  = ctrl_r.mem_write;
  assign branch     = ctrl_r.branch;
  assign mem_to_reg = ctrl_r.mem_to_reg;
  assign alu_op     = ctrl_r.alu_op;
  assign alu_src    = ctrl_r.alu_src;
  assign illegal    = ctrl_r.illegal;

endmodule

// File: tb/tb_main_control.sv
// tb_main_control
//   Scoreboard bench for main_control: stimulus pushes the expected control
//   word (from a reference table) into a queue at the capturing edge; a
//   monitor pops and compares one word per cycle, plus invariant checks.
module tb_main_control;

  logic       clk;
  logic       rst;
  logic [5:0] opcode;
  logic [1:0] reg_write;
  logic       mem_read;
  logic       mem_write;
  logic [1:0] branch;
  logic       mem_to_reg;
  logic [2:0] alu_op;
  logic       alu_src;
  logic       illegal;

  int checks   = 0;
  int failures = 0;

  // Expected words: {reg_write, mem_read, mem_write, branch, mem_to_reg, alu_op, alu_src, illegal}
  logic [11:0] exp_q[$];

  main_control dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .reg_write  (reg_write),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .branch     (branch),
    .mem_to_reg (mem_to_reg),
    .alu_op     (alu_op),
    .alu_src    (alu_src),
    .illegal    (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] word(input logic [1:0] rw, input logic mr, input logic mw,
                                       input logic [1:0] br, input logic m2r, input logic [2:0] aop,
                                       input logic asrc, input logic ill);
    return {rw, mr, mw, br, m2r, aop, asrc, ill};
  endfunction

  // Reference model: the decode table written out row by row.
  function automatic logic [11:0] ref_word(input logic [5:0] op);
    logic [11:0] tbl [0:9];
    tbl[0] = word(2'b01, 1'b0, 1'b0, 2'b00, 1'b0, 3'b001, 1'b0, 1'b0);
    tbl[1] = word(2'b01, 1'b0, 1'b0, 2'b00, 1'b0, 3'b010, 1'b0, 1'b0);
    tbl[2] = word(2'b01, 1'b0, 1'b0, 2'b00, 1'b0, 3'b011, 1'b1, 1'b0);
    tbl[3] = word(2'b01, 1'b0, 1'b0, 2'b00, 1'b0, 3'b100, 1'b1, 1'b0);
    tbl[4] = word(2'b01, 1'b1, 1'b0, 2'b00, 1'b1, 3'b011, 1'b1, 1'b0);
    tbl[5] = word(2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 3'b011, 1'b1, 1'b0);
    tbl[6] = word(2'b00, 1'b0, 1'b0, 2'b11, 1'b0, 3'b000, 1'b0, 1'b0);
    tbl[7] = word(2'b00, 1'b0, 1'b0, 2'b01, 1'b0, 3'b000, 1'b0, 1'b0);
    tbl[8] = word(2'b10, 1'b0, 1'b0, 2'b01, 1'b0, 3'b000, 1'b0, 1'b0);
    tbl[9] = word(2'b00, 1'b0, 1'b0, 2'b10, 1'b0, 3'b101, 1'b0, 1'b0);
    if ($isunknown(op) || op > 6'd9) return 12'h001;
    return tbl[op];
  endfunction

  function automatic logic [11:0] actual();
    return {reg_write, mem_read, mem_write, branch, mem_to_reg, alu_op, alu_src, illegal};
  endfunction

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_bit(input string name, input logic ok);
    checks++;
    if (ok !== 1'b1) begin
      failures++;
      $display("FAIL %s: invariant violated, word %b at %0t", name, actual(), $time);
    end
  endtask

  // Apply one opcode; the expected word is queued when the capturing edge passes.
  task automatic apply(input logic [5:0] op);
    opcode = op;
    @(posedge clk);
    exp_q.push_back(ref_word(op));
    #1;
  endtask

  // Monitor: each cycle the DUT presents a registered word; compare against the queue head.
  initial begin
    logic [11:0] e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("decode", actual(), e);
        check_bit("mem_rw_exclusive", !(mem_read && mem_write));
        check_bit("mem_to_reg_needs_read", !mem_to_reg || mem_read);
        check_bit("illegal_implies_nop", !illegal || (actual() == 12'h001));
      end
    end
  end

  initial begin
    rst    = 1'b1;
    opcode = 6'd0;
    @(posedge clk);
    #1;
    check("reset_state", actual(), 12'h000);
    @(negedge clk);
    rst = 1'b0;

    // Sweep legal opcodes.
    for (int i = 0; i < 10; i++) apply(6'(i));
    // Targeted rows and illegal boundaries.
    apply(6'd8);
    apply(6'd6);
    apply(6'd10);
    apply(6'd37);
    apply(6'd63);
    // Store then load back to back.
    apply(6'd5);
    apply(6'd4);
    // Unknown opcode decodes as illegal.
    apply(6'bxxxxxx);

    // Asynchronous reset mid-cycle after loading opcode 4.
    apply(6'd4);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_immediate", actual(), 12'h000);
    @(posedge clk);
    #1;
    check("reset_hold", actual(), 12'h000);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_release_no_early_decode", actual(), 12'h000);
    apply(6'd4);

    // Random opcodes, biased toward the legal range.
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 1) == 0) apply(6'($urandom_range(0, 9)));
      else apply(6'($urandom_range(0, 63)));
    end

    @(posedge clk);
    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
